// File: rtl/score_ram_arbiter.sv
// Two-requester arbiter in front of a single-port score RAM with a fixed read latency.
// Define SCORE_ARB_ROUNDROBIN_EN for round-robin tie-breaking; otherwise req0 wins ties.
module score_ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Last value the wait counter reaches before CAPTURE; unused when RD_LAT is 1.
  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t              r_state;
  logic                r_owner;
  logic                r_we;
  logic [1:0]          r_wait_cnt;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data;
  logic                r_ram_wren;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_done0;
  logic                r_done1;
  logic                w_idle;
  logic                w_any;
  logic                w_win1;

  assign w_idle = (r_state == IDLE);
  assign w_any  = req0 | req1;

`ifdef SCORE_ARB_ROUNDROBIN_EN
  logic r_last;
  // On a tie the requester that was not served last wins.
  assign w_win1 = req1 & (~req0 | ~r_last);
`else
  assign w_win1 = req1 & ~req0;
`endif

  // Grant is a Mealy pulse in the IDLE cycle where the request is sampled.
  assign gnt0 = rst & w_idle & req0 & ~w_win1;
  assign gnt1 = rst & w_idle & w_win1;

  assign done0    = r_done0;
  assign done1    = r_done1;
  assign rdata    = r_rdata;
  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;
  assign ram_wren = r_ram_wren;
  assign busy     = ~w_idle;
  assign o_state  = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_wait_cnt <= 2'd0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_wren <= 1'b0;
      r_rdata    <= '0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
`ifdef SCORE_ARB_ROUNDROBIN_EN
      r_last     <= 1'b1;
`endif
    end else begin
      r_ram_wren <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner    <= w_win1;
            r_we       <= w_win1 ? we1 : we0;
            r_ram_addr <= w_win1 ? addr1 : addr0;
            r_ram_data <= w_win1 ? wdata1 : wdata0;
            r_ram_wren <= w_win1 ? we1 : we0;
`ifdef SCORE_ARB_ROUNDROBIN_EN
            r_last     <= w_win1;
`endif
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_state <= DONE;
          end else begin
            r_wait_cnt <= 2'd0;
            r_state    <= (RD_LAT == 1) ? CAPTURE : WAIT;
          end
        end
        WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= CAPTURE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        CAPTURE: begin
          r_rdata <= ram_q;
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/score_ram_arbiter.md
SCORE_RAM_ARBITER -- requirements
Module: score_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning RAM address width.
REQ-002 SHALL have parameter DATA_W, default 14, meaning score word width.
REQ-003 SHALL have parameter RD_LAT, default 2, meaning RAM read latency in cycles (range 1..3).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0/req1  input  1  per-requester access request (level).
REQ-007 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports addr0/addr1  input  ADDR_W  target address.
REQ-009 SHALL have ports wdata0/wdata1  input  DATA_W  write data.
REQ-010 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse.
REQ-011 SHALL have ports done0/done1  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  DATA_W  read result; valid while done0 or done1 is high, held until the next read capture.
REQ-013 SHALL have ports ram_addr  output  ADDR_W; ram_data  output  DATA_W; ram_wren  output  1; ram_q  input  DATA_W: single-port score RAM side.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, CAPTURE, DONE.
REQ-016 IDLE: req0/req1 sampled only here; on any request, latch the winner's we, addr and wdata, pulse its gnt for that cycle, go to ISSUE.
REQ-017 ISSUE: drive latched ram_addr and ram_data; ram_wren = latched we for exactly this cycle; write goes to DONE, read goes to WAIT with the wait counter cleared.
REQ-018 WAIT: hold ram_addr; count RD_LAT-1 cycles, then go to CAPTURE (RD_LAT=1 passes through WAIT for zero extra cycles, i.e. straight to CAPTURE).
REQ-019 CAPTURE: rdata <= ram_q; go to DONE.
REQ-020 DONE: pulse the winner's done for one cycle; return to IDLE.
REQ-021 Latency: write gnt-to-done = 2 cycles; read gnt-to-done = RD_LAT+2 cycles.
REQ-022 ram_wren SHALL be 0 in every state except ISSUE of a write; ram_addr/ram_data hold last values otherwise.
REQ-023 Requests seen outside IDLE SHALL be ignored; a req still high in the IDLE cycle after done starts a new transaction.
REQ-024 Single request in IDLE SHALL be granted immediately irrespective of arbitration pointer.
REQ-025 gnt0/gnt1 and done0/done1 SHALL never be high simultaneously.
REQ-026 Write data SHALL be stored unmodified (no truncation); address wrap is the caller's responsibility.

Reset
REQ-027 rst low SHALL immediately force IDLE, all gnt/done 0, ram_wren 0, busy 0, ram_addr 0, ram_data 0, rdata 0, wait counter 0, last-served pointer = 1.
REQ-028 Reset asserted mid-transaction SHALL abort it with no done pulse; the pending write is dropped if ISSUE had not completed.

Configuration
REQ-029 Macro SCORE_ARB_ROUNDROBIN_EN defined: on simultaneous requests grant the requester not last served; pointer updates on every grant.
REQ-030 Macro not defined: fixed priority, req0 always wins a tie; pointer logic absent.

Verification
REQ-031 req0 write addr=2 wdata=14'd1200 -> gnt0 cycle N, ram_wren=1 with ram_addr=2, ram_data=1200 at N+1, done0 at N+2.
REQ-032 req1 read addr=2 with RAM holding 1200, RD_LAT=2 -> gnt1 at N, done1 at N+4, rdata=1200.
REQ-033 req0 and req1 both high for 3 transactions, round-robin build -> grants 0,1,0; fixed-priority build -> 0,0,0.
REQ-034 req1 asserted while busy serving req0 -> no gnt1 until the IDLE cycle after done0.
REQ-035 rst low during WAIT of a read -> busy 0 and no done pulse within the same cycle; next request is granted normally.
REQ-036 RD_LAT=1 read of addr=31 holding 14'h3FFF -> done at N+3, rdata=16383.
